// File: rtl/decode_queue_unit.sv
// RISC-V decode queue: decodes on enqueue, buffers decoded entries in a DEPTH-deep FIFO.
// Optional vector decode is enabled by defining CORE101_VEC_DECODE_EN.
module decode_queue_unit #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                       clock_in,
    input  logic                       reset_in,
    input  logic                       flush_in,
    input  logic                       ins_valid_in,
    output logic                       ins_ready_out,
    input  logic [31:0]                ins_in,
    input  logic [PC_WIDTH-1:0]        pc_in,
    output logic                       dec_valid_out,
    input  logic                       dec_ready_in,
    output logic [2:0]                 exec_unit_sel_out,
    output logic [3:0]                 exec_unit_uop_out,
    output logic                       pc_mux_sel_out,
    output logic                       imm_mux_sel_out,
    output logic                       illegal_out,
    output logic [4:0]                 rs1_out,
    output logic [4:0]                 rs2_out,
    output logic [4:0]                 rd_out,
    output logic [PC_WIDTH-1:0]        pc_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;
    localparam logic [4:0] OPC_OPV    = 5'b10101;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_INT  = 3'b001;
    localparam logic [2:0] SEL_LSU  = 3'b010;
    localparam logic [2:0] SEL_VEC  = 3'b100;

    typedef struct packed {
        logic [2:0]          sel;
        logic [3:0]          uop;
        logic                pc_mux;
        logic                imm_mux;
        logic                illegal;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    entry_t              mem [DEPTH];
    entry_t              dec;
    entry_t              head;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                push;
    logic                pop;

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;

    assign opcode = ins_in[6:2];
    assign funct3 = ins_in[14:12];
    assign funct7 = ins_in[31:25];

    // Decode of the offered instruction; illegal encodings carry only the flag
    // and register fields so no functional unit or operand mux is selected.
    always_comb begin
        dec         = '0;
        bad         = 1'b0;
        dec.rs1     = ins_in[19:15];
        dec.rs2     = ins_in[24:20];
        dec.rd      = ins_in[11:7];
        dec.pc      = pc_in;
        if (ins_in[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD: begin
                    dec.sel     = SEL_LSU;
                    dec.uop     = {1'b0, funct3};
                    dec.imm_mux = 1'b1;
                    bad         = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                end
                OPC_STORE: begin
                    dec.sel     = SEL_LSU;
                    dec.uop     = {1'b1, funct3};
                    dec.imm_mux = 1'b1;
                    bad         = (funct3 > 3'b010);
                end
                OPC_OPIMM: begin
                    dec.sel     = SEL_INT;
                    dec.uop     = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                    dec.imm_mux = 1'b1;
                    bad         = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                                  ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
                                   (funct7 != 7'b0100000));
                end
                OPC_AUIPC: begin
                    dec.sel     = SEL_INT;
                    dec.pc_mux  = 1'b1;
                    dec.imm_mux = 1'b1;
                end
                OPC_OP: begin
                    dec.sel = SEL_INT;
                    dec.uop = {funct7[5], funct3};
                    bad     = (funct7 != 7'b0000000) &&
                              !((funct7 == 7'b0100000) &&
                                ((funct3 == 3'b000) || (funct3 == 3'b101)));
                end
                OPC_LUI: begin
                    dec.sel     = SEL_INT;
                    dec.imm_mux = 1'b1;
                end
                OPC_BRANCH: begin
                    dec.sel    = SEL_INT;
                    dec.uop    = {1'b0, funct3};
                    dec.pc_mux = 1'b1;
                    bad        = (funct3 == 3'b010) || (funct3 == 3'b011);
                end
                OPC_JALR, OPC_JAL: begin
                    dec.sel     = SEL_INT;
                    dec.pc_mux  = 1'b1;
                    dec.imm_mux = 1'b1;
                end
                OPC_SYSTEM: begin
                    dec.sel = SEL_INT;
                end
`ifdef CORE101_VEC_DECODE_EN
                OPC_OPV: begin
                    dec.sel = SEL_VEC;
                    dec.uop = {1'b0, funct3};
                end
`endif
                default: bad = 1'b1;
            endcase
        end
        if (bad) begin
            dec.sel     = SEL_NONE;
            dec.uop     = 4'b0000;
            dec.pc_mux  = 1'b0;
            dec.imm_mux = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    // Ready is derived from registered occupancy only, so a full queue refuses
    // an offer even in a cycle where the head is being consumed.
    assign ins_ready_out = (count < (AW+1)'(DEPTH));
    assign dec_valid_out = (count != '0);
    assign push          = ins_valid_in && ins_ready_out;
    assign pop           = dec_valid_out && dec_ready_in;
    assign count_out     = count;

    always_ff @(posedge clock_in) begin
        if (reset_in || flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (push && !flush_in && !reset_in) mem[wr_ptr] <= dec;
    end

    assign head = dec_valid_out ? mem[rd_ptr] : '0;

    assign exec_unit_sel_out = head.sel;
    assign exec_unit_uop_out = head.uop;
    assign pc_mux_sel_out    = head.pc_mux;
    assign imm_mux_sel_out   = head.imm_mux;
    assign illegal_out       = head.illegal;
    assign rs1_out           = head.rs1;
    assign rs2_out           = head.rs2;
    assign rd_out            = head.rd;
    assign pc_out            = head.pc;

endmodule
